// File: rtl/regfile_pkg.sv
// Shared constants and types for the registerfile_sb register file and its scoreboard.
package regfile_pkg;

    localparam int REGFILE_WIDTH = 32;
    localparam int REGFILE_INDEX = 5;
    localparam int REGFILE_NREAD = 2;

    typedef logic [REGFILE_INDEX-1:0] reg_addr_t;
    typedef logic [REGFILE_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at writeback.
// Bit 0 is constant zero. Reset beats set, and set beats clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int INDEX = REGFILE_INDEX
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  set_in,
    input  logic [INDEX-1:0]      set_address_in,
    input  logic                  clear_in,
    input  logic [INDEX-1:0]      clear_address_in,
    output logic [2**INDEX-1:0]   busy_out,
    output logic                  any_busy_out
);

    localparam int DEPTH = 2**INDEX;
    localparam logic [DEPTH-1:0] NONZERO_MASK = {{(DEPTH-1){1'b1}}, 1'b0};

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clear_mask;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        set_mask                   = '0;
        clear_mask                 = '0;
        set_mask[set_address_in]   = set_in;
        clear_mask[clear_address_in] = clear_in;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clear_mask) | set_mask) & NONZERO_MASK;
        end
    end

    assign busy_out     = busy_q;
    assign any_busy_out = |busy_q;

endmodule

// File: rtl/registerfile_sb.sv
// Register file with NREAD combinational read ports, one write port, and an integrated scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports and mask their busy flags.
module registerfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int INDEX = REGFILE_INDEX,
    parameter int NREAD = REGFILE_NREAD
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   we_in,
    input  logic [INDEX-1:0]       address_w_in,
    input  logic [WIDTH-1:0]       data_w_in,
    input  logic [NREAD*INDEX-1:0] address_r_in,
    output logic [NREAD*WIDTH-1:0] data_r_out,
    input  logic                   issue_in,
    input  logic [INDEX-1:0]       address_issue_in,
    output logic [NREAD-1:0]       busy_r_out,
    output logic                   any_busy_out
);

    localparam int DEPTH = 2**INDEX;

    logic [WIDTH-1:0] reg_file [1:DEPTH-1];
    logic [DEPTH-1:0] busy;

    // NOTE: storage is reset explicitly because reads after reset must return zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 1; i < DEPTH; i++) begin
                reg_file[i] <= '0;
            end
        end else if (we_in && address_w_in != '0) begin
            reg_file[address_w_in] <= data_w_in;
        end
    end

    regfile_scoreboard #(
        .INDEX (INDEX)
    ) u_scoreboard (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .set_in           (issue_in),
        .set_address_in   (address_issue_in),
        .clear_in         (we_in),
        .clear_address_in (address_w_in),
        .busy_out         (busy),
        .any_busy_out     (any_busy_out)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [INDEX-1:0] addr;
        logic [WIDTH-1:0] stored;

        assign addr   = address_r_in[k*INDEX +: INDEX];
        assign stored = (addr == '0) ? '0 : reg_file[addr];

`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd = we_in && (addr == address_w_in) && (addr != '0);
        assign data_r_out[k*WIDTH +: WIDTH] = fwd ? data_w_in : stored;
        assign busy_r_out[k]                = busy[addr] & ~fwd;
`else
        assign data_r_out[k*WIDTH +: WIDTH] = stored;
        assign busy_r_out[k]                = busy[addr];
`endif
    end

endmodule

// File: tb/tb_registerfile_sb.sv
// Bench for registerfile_sb: directed vector table for the corner cases, then random traffic
// compared against an array-based reference model.
module tb_registerfile_sb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                                 clk_in = 1'b0;
    logic                                 rst_in;
    logic                                 we_in;
    reg_addr_t                            address_w_in;
    reg_word_t                            data_w_in;
    logic [REGFILE_NREAD*REGFILE_INDEX-1:0] address_r_in;
    logic [REGFILE_NREAD*REGFILE_WIDTH-1:0] data_r_out;
    logic                                 issue_in;
    reg_addr_t                            address_issue_in;
    logic [REGFILE_NREAD-1:0]             busy_r_out;
    logic                                 any_busy_out;

    int n_vec = 0;
    int n_err = 0;

    reg_word_t m_mem  [32];
    bit        m_busy [32];

    registerfile_sb dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .we_in            (we_in),
        .address_w_in     (address_w_in),
        .data_w_in        (data_w_in),
        .address_r_in     (address_r_in),
        .data_r_out       (data_r_out),
        .issue_in         (issue_in),
        .address_issue_in (address_issue_in),
        .busy_r_out       (busy_r_out),
        .any_busy_out     (any_busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit        rst;
        bit        we;
        reg_addr_t aw;
        reg_word_t dw;
        bit        issue;
        reg_addr_t ai;
        reg_addr_t ra0;
        reg_addr_t ra1;
        reg_word_t exp_d0;
        reg_word_t exp_d1;
        bit [1:0]  exp_busy;
        bit        exp_any;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, bit we, reg_addr_t aw, reg_word_t dw, bit issue,
                                reg_addr_t ai, reg_addr_t ra0, reg_addr_t ra1, reg_word_t d0,
                                reg_word_t d1, bit [1:0] busy, bit any);
        vec_t v;
        v.rst = rst; v.we = we; v.aw = aw; v.dw = dw; v.issue = issue; v.ai = ai;
        v.ra0 = ra0; v.ra1 = ra1; v.exp_d0 = d0; v.exp_d1 = d1; v.exp_busy = busy; v.exp_any = any;
        return v;
    endfunction

    task automatic drive(input bit rst, input bit we, input reg_addr_t aw, input reg_word_t dw,
                         input bit issue, input reg_addr_t ai, input reg_addr_t ra0,
                         input reg_addr_t ra1);
        rst_in = rst; we_in = we; address_w_in = aw; data_w_in = dw;
        issue_in = issue; address_issue_in = ai;
        address_r_in = {ra1, ra0};
        #1;
    endtask

    // Architectural effect of one clock edge, taken straight from the register/scoreboard rules.
    task automatic model_edge();
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we_in && address_w_in != 0) begin
                m_mem[address_w_in]  = data_w_in;
                m_busy[address_w_in] = 1'b0;
            end
            if (issue_in && address_issue_in != 0) m_busy[address_issue_in] = 1'b1;
        end
    endtask

    task automatic clock_edge();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
    endtask

    function automatic reg_word_t model_read(reg_addr_t a);
        if (a == 0) return '0;
        if (BYP && we_in && address_w_in == a) return data_w_in;
        return m_mem[a];
    endfunction

    function automatic bit model_busy(reg_addr_t a);
        if (a == 0) return 1'b0;
        if (BYP && we_in && address_w_in == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit model_any();
        bit any = 1'b0;
        for (int i = 1; i < 32; i++) any |= m_busy[i];
        return any;
    endfunction

    initial begin
        reg_word_t pd;
        reg_addr_t ra0, ra1;

        // Directed table; each row's expectations are the outputs before that row's clock edge.
        tbl.push_back(mk(0,0,0,0,0,0, 5,31, 0,0, 2'b00,0));
        tbl.push_back(mk(0,1,7,32'hDEADBEEF,0,0, 7,7,
                         BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 2'b00,0));
        tbl.push_back(mk(0,0,0,0,0,0, 7,7, 32'hDEADBEEF,32'hDEADBEEF, 2'b00,0));
        tbl.push_back(mk(0,1,0,32'h12345678,0,0, 0,7, 0,32'hDEADBEEF, 2'b00,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0, 2'b00,0));
        tbl.push_back(mk(0,0,0,0,1,9, 9,9, 0,0, 2'b00,0));
        tbl.push_back(mk(0,0,0,0,0,0, 9,9, 0,0, 2'b11,1));
        tbl.push_back(mk(0,1,9,32'h55,0,0, 9,5, BYP ? 32'h55 : 32'h0, 0, BYP ? 2'b00 : 2'b01,1));
        tbl.push_back(mk(0,0,0,0,0,0, 9,9, 32'h55,32'h55, 2'b00,0));
        tbl.push_back(mk(0,0,0,0,1,4, 4,3, 0,0, 2'b00,0));
        tbl.push_back(mk(0,1,4,32'h44,1,4, 3,4, 0, BYP ? 32'h44 : 32'h0, BYP ? 2'b00 : 2'b10,1));
        tbl.push_back(mk(0,0,0,0,0,0, 4,4, 32'h44,32'h44, 2'b11,1));
        tbl.push_back(mk(0,0,0,0,1,0, 0,4, 0,32'h44, 2'b10,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,4, 0,32'h44, 2'b10,1));
        tbl.push_back(mk(0,1,3,32'hA5A5A5A5,0,0, 4,3, 32'h44, BYP ? 32'hA5A5A5A5 : 32'h0, 2'b01,1));
        tbl.push_back(mk(0,0,0,0,1,2, 3,2, 32'hA5A5A5A5,0, 2'b00,1));
        tbl.push_back(mk(0,0,0,0,1,6, 2,6, 0,0, 2'b01,1));
        tbl.push_back(mk(1,0,0,0,0,0, 2,6, 0,0, 2'b11,1));
        tbl.push_back(mk(0,0,0,0,0,0, 7,9, 0,0, 2'b00,0));
        tbl.push_back(mk(1,1,8,32'h88,0,0, 4,5, 0,0, 2'b00,0));
        tbl.push_back(mk(0,0,0,0,0,0, 8,8, 0,0, 2'b00,0));

        // Initial reset, held for two edges.
        @(negedge clk_in);
        drive(1,0,0,0,0,0,0,0);
        clock_edge();
        clock_edge();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].aw, tbl[i].dw, tbl[i].issue, tbl[i].ai,
                  tbl[i].ra0, tbl[i].ra1);
            check($sformatf("v%0d d0", i), data_r_out[31:0],  tbl[i].exp_d0);
            check($sformatf("v%0d d1", i), data_r_out[63:32], tbl[i].exp_d1);
            check($sformatf("v%0d busy", i), {30'd0, busy_r_out}, {30'd0, tbl[i].exp_busy});
            check($sformatf("v%0d any", i), {31'd0, any_busy_out}, {31'd0, tbl[i].exp_any});
            clock_edge();
        end

        // Random traffic on a small address window to provoke hazards, against the model.
        for (int c = 0; c < 400; c++) begin
            pd  = $urandom;
            ra0 = reg_addr_t'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            ra1 = reg_addr_t'($urandom_range(0, 7));
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                  reg_addr_t'($urandom_range(0, 7)), pd, $urandom_range(0, 2) != 0,
                  reg_addr_t'($urandom_range(0, 7)), ra0, ra1);
            check($sformatf("rnd%0d d0", c), data_r_out[31:0],  model_read(ra0));
            check($sformatf("rnd%0d d1", c), data_r_out[63:32], model_read(ra1));
            check($sformatf("rnd%0d busy", c), {30'd0, busy_r_out},
                  {30'd0, model_busy(ra1), model_busy(ra0)});
            check($sformatf("rnd%0d any", c), {31'd0, any_busy_out}, {31'd0, model_any()});
            clock_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
